// File: rtl/mc_ctrl_fsm.sv
// Multicycle CPU control FSM: sequences fetch/decode/execute/memory/writeback,
// drives datapath control strobes and counts retired instructions.
module mc_ctrl_fsm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        ir_wr,
  output logic        pc_wr,
  output logic [1:0]  pc_src,
  output logic        reg_wr,
  output logic        reg_des,
  output logic        alu_src,
  output logic        mem2reg,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        illegal,
  output logic [2:0]  state,
  output logic [15:0] retired
);

  localparam int unsigned OP_W  = 4;
  localparam int unsigned RET_W = 16;

  localparam logic [OP_W-1:0] OP_SHL  = 4'h5;
  localparam logic [OP_W-1:0] OP_ST   = 4'h6;
  localparam logic [OP_W-1:0] OP_LD   = 4'h7;
  localparam logic [OP_W-1:0] OP_SLI  = 4'h8;
  localparam logic [OP_W-1:0] OP_BR   = 4'h9;
  localparam logic [OP_W-1:0] OP_JUMP = 4'hA;

  localparam logic [1:0] PC_SEQ  = 2'b00;
  localparam logic [1:0] PC_BR   = 2'b01;
  localparam logic [1:0] PC_JUMP = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [RET_W-1:0] retired_q, retired_d;

  logic is_rtype, is_st, is_ld, is_sli, is_br, is_jump;

  // Instruction class of the opcode captured in DECODE.
  assign is_rtype = (op_q <= OP_SHL);
  assign is_st    = (op_q == OP_ST);
  assign is_ld    = (op_q == OP_LD);
  assign is_sli   = (op_q == OP_SLI);
  assign is_br    = (op_q == OP_BR);
  assign is_jump  = (op_q == OP_JUMP);

  assign state   = 3'(state_q);
  assign retired = retired_q;

  // State, latched opcode and retire counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      retired_q <= retired_d;
    end
  end

  // Next-state, opcode capture, retire increment and control strobes.
  always_comb begin
    logic retire;
    state_d   = state_q;
    op_d      = op_q;
    retired_d = retired_q;
    retire    = 1'b0;
    ir_wr     = 1'b0;
    pc_wr     = 1'b0;
    pc_src    = PC_SEQ;
    reg_wr    = 1'b0;
    reg_des   = 1'b0;
    alu_src   = 1'b0;
    mem2reg   = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    illegal   = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_rd = 1'b1;
        if (mem_ready) begin
          ir_wr   = 1'b1;
          pc_wr   = 1'b1;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        op_d    = opcode;
        state_d = (opcode > OP_JUMP) ? S_TRAP : S_EXEC;
      end

      S_EXEC: begin
        if (is_ld || is_st) begin
          alu_src = 1'b1;
          state_d = S_MEM;
        end else if (is_sli) begin
          alu_src = 1'b1;
          state_d = S_WB;
        end else if (is_rtype) begin
          reg_des = 1'b1;
          state_d = S_WB;
        end else if (is_br) begin
          pc_src  = PC_BR;
          pc_wr   = zero;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (is_jump) begin
          pc_src  = PC_JUMP;
          pc_wr   = 1'b1;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_FETCH;
        end
      end

      S_MEM: begin
        alu_src = 1'b1;
        if (is_ld) begin
          mem_rd = 1'b1;
          if (mem_ready) state_d = S_WB;
        end else if (is_st) begin
          mem_wr = 1'b1;
          if (mem_ready) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        end else begin
          state_d = S_FETCH;
        end
      end

      S_WB: begin
        reg_wr  = 1'b1;
        reg_des = is_rtype;
        mem2reg = is_ld;
        retire  = 1'b1;
        state_d = S_FETCH;
      end

      S_TRAP: begin
        illegal = 1'b1;
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase

    if (retire) retired_d = retired_q + RET_W'(1);

    // While in reset the FETCH strobes must not follow mem_ready.
    if (!rst_n) begin
      ir_wr = 1'b0;
      pc_wr = 1'b0;
    end
  end

endmodule

// File: doc/mc_ctrl_fsm.md
MC_CTRL_FSM -- requirements
Module: mc_ctrl_fsm

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port opcode, input, 4 bits: instruction opcode from IR; valid from DECODE onward.
REQ-004 SHALL have port zero, input, 1 bit: ALU zero flag; used in EXEC for br.
REQ-005 SHALL have port mem_ready, input, 1 bit: memory access complete this cycle.
REQ-006 SHALL have port ir_wr, output, 1 bit: load IR.
REQ-007 SHALL have port pc_wr, output, 1 bit: load PC.
REQ-008 SHALL have port pc_src, output, 2 bits: next-PC select (00 = PC+1, 01 = branch target, 10 = jump target).
REQ-009 SHALL have the following datapath-control ports, each output, 1 bit, with meaning as named: reg_wr, reg_des, alu_src, mem2reg, mem_rd, mem_wr.
REQ-010 SHALL have port illegal, output, 1 bit: sticky trap flag.
REQ-011 SHALL have port state, output, 3 bits: current state, for debug.
REQ-012 SHALL have port retired, output, 16 bits: count of completed instructions.

Function
REQ-013 SHALL decode opcodes as follows: 0 add, 1 sub, 2 lt, 3 or, 4 and, 5 shl (together R-type), 6 st, 7 ld, 8 sli, 9 br, A jump; B-F are illegal.
REQ-014 SHALL implement these state encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; codes 6-7 SHALL go to FETCH on the next clock.
REQ-015 SHALL behave in FETCH as follows: mem_rd=1 and pc_src=00; when mem_ready=1, assert ir_wr=1 and pc_wr=1 for that cycle and go to DECODE; otherwise hold in FETCH.
REQ-016 SHALL behave in DECODE as follows: latch opcode into an internal register; if illegal go to TRAP, else go to EXEC; assert no outputs.
REQ-017 SHALL drive all EXEC, MEM and WB outputs from the latched opcode only; opcode changes after DECODE SHALL have no effect.
REQ-018 SHALL behave in EXEC as follows: alu_src=1 for ld/st/sli; reg_des=1 for R-type; next state is WB for R-type/sli and MEM for ld/st.
REQ-019 SHALL behave in EXEC for br as follows: pc_src=01, pc_wr=zero, go to FETCH, increment retired.
REQ-020 SHALL behave in EXEC for jump as follows: pc_src=10, pc_wr=1, go to FETCH, increment retired.
REQ-021 SHALL behave in MEM as follows: alu_src=1; for ld, assert mem_rd=1; for st, assert mem_wr=1; hold while mem_ready=0.
REQ-022 SHALL, in MEM with mem_ready=1, go to WB for ld; for st, go to FETCH and increment retired.
REQ-023 SHALL behave in WB as follows: reg_wr=1 for exactly one cycle; reg_des=1 for R-type; mem2reg=1 for ld; go to FETCH and increment retired.
REQ-024 SHALL behave in TRAP as follows: illegal=1; all other outputs 0; remain in TRAP until rst_n is asserted.
REQ-025 SHALL, outside the states listed above, hold every control output at 0; mem_rd and mem_wr SHALL never be asserted together.
REQ-026 SHALL make retired a 16-bit counter that wraps from FFFF to 0000 with no flag.
REQ-027 SHALL meet these latencies with zero-wait memory (mem_ready=1 each cycle): R-type/sli 4 cycles, ld 5, st 4, br/jump 3; each wait cycle adds one.
REQ-028 SHALL treat mem_ready as ignored in DECODE, EXEC, WB and TRAP.

Reset
REQ-029 SHALL, while rst_n=0, asynchronously force state=FETCH, latched opcode=0, illegal=0 and retired=0.
REQ-030 SHALL, during reset, hold all outputs at their FETCH values: mem_rd=1, and every other control output 0.
REQ-031 SHALL, when reset is asserted mid-instruction (including while a memory access is pending), abort the instruction with no reg_wr or pc_wr pulse; the first edge after release evaluates FETCH.

Verification
REQ-032 SHALL verify an R-type instruction: opcode=0, mem_ready=1 -> states 0,1,2,4,0; reg_wr=1 in cycle 4 only; retired 0->1.
REQ-033 SHALL verify a ld with a wait state: opcode=7, mem_ready low for 2 cycles in MEM -> 7 cycles total; mem_rd=1 throughout MEM; mem2reg=1 and reg_wr=1 in WB.
REQ-034 SHALL verify branch taken and not taken: opcode=9 with zero=1 -> pc_wr=1 and pc_src=01 in EXEC; with zero=0 -> pc_wr=0; retired increments in both cases.
REQ-035 SHALL verify the illegal trap: opcode=C -> TRAP at cycle 3; illegal=1 is held for 20 cycles with any inputs; rst_n low clears it to FETCH.
REQ-036 SHALL verify reset mid-operation: rst_n dropped in MEM of a st -> immediately state=0 and mem_wr=0, with no retired increment.
REQ-037 SHALL verify counter wrap: preload via 65536 jump instructions -> retired returns to 0000.
